mem_sweep_bist: RTL and testbench
=================================

MEM_SWEEP_BIST -- requirements
Module: mem_sweep_bist

Interface
REQ-001 Parameters: ADDR_W, default 16, memory address width; DATA_W, default 8, memory data width; RD_LAT, default 1, memory read latency in cycles (legal values 1..4); ERR_W, default 16, error-counter width.
REQ-002 Port clka  in  1  the single clock; all logic rises on clka.
REQ-003 Port rsta  in  1  synchronous, active-high reset.
REQ-004 Port start  in  1  one-cycle pulse that begins a sweep; sampled only in IDLE.
REQ-005 Port mode  in  2  00 read-sweep/checksum, 01 write-only, 10 write-then-verify, 11 behaves as 00.
REQ-006 Port addr_lo, addr_hi  in  ADDR_W  inclusive sweep bounds; latched on accepted start.
REQ-007 Port key  in  DATA_W  pattern key; latched on accepted start.
REQ-008 Port ena, wea  out  1  memory enable and write enable.
REQ-009 Port addra  out  ADDR_W  memory address.
REQ-010 Port dina  out  DATA_W  memory write data.
REQ-011 Port douta  in  DATA_W  memory read data, valid RD_LAT cycles after its read was issued.
REQ-012 Port busy  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-013 Port done  out  1  one-cycle completion pulse.
REQ-014 Port pass  out  1  result; held until the next accepted start.
REQ-015 Port err_count  out  ERR_W  number of miscompares; saturates.
REQ-016 Port first_err_addr  out  ADDR_W  address of the first miscompare.
REQ-017 Port checksum  out  DATA_W  XOR of all data read in mode 00.

Function
REQ-018 FSM states: IDLE, WRITE, READ, DRAIN, DONE.
REQ-019 IDLE + start -> latch mode/bounds/key, clear err_count/first_err_addr/checksum/pass; go to WRITE (modes 01, 10) or READ (modes 00, 11).
REQ-020 Pattern: data(addr) = addr[DATA_W-1:0] XOR key; upper address bits are zero-extended when DATA_W > ADDR_W.
REQ-021 WRITE: one write per cycle (ena=1, wea=1), addresses addr_lo upward through addr_hi, dina=data(addra).
REQ-022 After the addr_hi write: mode 01 goes to DONE; mode 10 goes to READ in the next cycle, restarting at addr_lo.
REQ-023 READ: one read per cycle (ena=1, wea=0) from addr_lo through addr_hi; after the addr_hi read, go to DRAIN.
REQ-024 A RD_LAT-deep shift register of {valid, addr} tracks reads in flight; douta is consumed when the entry exits the register.
REQ-025 Mode 10 compare: a douta value that differs from data(addr) increments err_count; the first miscompare loads first_err_addr.
REQ-026 err_count saturates at 2^ERR_W-1 and never wraps.
REQ-027 Mode 00/11: checksum ^= douta for each consumed read; no compares are made.
REQ-028 DRAIN lasts exactly RD_LAT cycles with ena=0, then goes to DONE.
REQ-029 DONE: one cycle; done=1; pass=(err_count==0); return to IDLE.
REQ-030 The address counter stops at addr_hi and never increments past it; addr_hi=2^ADDR_W-1 produces no wrap and no extra access.
REQ-031 If addr_lo > addr_hi, the sweep is empty: go directly to DONE in the cycle after start; no accesses; pass=1; checksum=0.
REQ-032 start outside IDLE is ignored; start in the DONE cycle is ignored.
REQ-033 In IDLE, DRAIN and DONE: ena=0 and wea=0.
REQ-034 Latency from start to the first access is 1 cycle.
REQ-035 Total sweep length for N = addr_hi-addr_lo+1: mode 10 is 2N+RD_LAT+1 cycles from start to done; mode 00 is N+RD_LAT+1.

Reset
REQ-036 rsta=1 at a clka edge forces IDLE, including mid-sweep, and clears all in-flight reads.
REQ-037 Reset values: ena=0, wea=0, addra=0, dina=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, checksum=0.
REQ-038 Outputs take their reset values in the cycle after the reset edge; no memory access is issued while rsta=1.

Verification
REQ-039 Mode 10, lo=0x0000, hi=0x00FF, key=0xA5, memory model correct -> 256 writes then 256 reads; done at start+2*256+RD_LAT+1; pass=1; err_count=0.
REQ-040 As REQ-039, but the model forces bit 0 on reads at 0x0010 and 0x0020 -> err_count=2, first_err_addr=0x0010, pass=0.
REQ-041 Mode 00, lo=hi=0xFFFF, memory holds 0x3C -> exactly one read at 0xFFFF with no wrap to 0x0000; checksum=0x3C; pass=1.
REQ-042 Mode 01, lo=0x0005, hi=0x0003 -> no ena pulse; done one cycle after start; pass=1.
REQ-043 Mode 10 with RD_LAT=2; assert rsta during READ at address 0x0040 -> in the next cycle ena=0, busy=0, err_count=0, state IDLE; a later start runs normally.
REQ-044 Mode 10, ERR_W=4, every read corrupted over 32 addresses -> err_count=15 (saturated), first_err_addr=lo.

Source files
------------

// File: rtl/mem_sweep_bist.sv
// mem_sweep_bist: address-sweep memory BIST with write, verify and checksum modes
// Ports: clka/rsta clock and sync reset; start/mode/addr_lo/addr_hi/key sweep request;
// ena/wea/addra/dina/douta memory port; busy/done/pass/err_count/first_err_addr/checksum status.
module mem_sweep_bist #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [DATA_W-1:0] key,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  logic [2:0]        state_q, state_d, drain_q, drain_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] lo_q, hi_q, addr_q, addr_d, first_q, first_d;
  logic [DATA_W-1:0] key_q, cks_q, cks_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, at_hi, consume, miss;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] pa_q [RD_LAT];

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] k);
    return DATA_W'(a) ^ k;
  endfunction

  assign at_hi   = addr_q == hi_q;
  assign consume = vld_q[RD_LAT-1];
  assign miss    = consume && mode_q == 2'b10 && douta != pat(pa_q[RD_LAT-1], key_q);

  // Reset gates the strobes combinationally so no access escapes while rsta is high.
  assign ena            = (state_q == WRITE || state_q == READ) && !rsta;
  assign wea            = state_q == WRITE && !rsta;
  assign addra          = addr_q;
  assign dina           = wea ? pat(addr_q, key_q) : '0;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign checksum       = cks_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    err_d   = (miss && err_q != '1) ? err_q + 1'b1 : err_q;
    first_d = (miss && err_q == '0) ? pa_q[RD_LAT-1] : first_q;
    cks_d   = (consume && mode_q != 2'b10) ? cks_q ^ douta : cks_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (addr_lo > addr_hi) ? DONE : (mode == 2'b01 || mode == 2'b10) ? WRITE : READ;
        addr_d  = addr_lo;
      end
      WRITE: if (at_hi) begin
        state_d = (mode_q == 2'b01) ? DONE : READ;
        addr_d  = lo_q;
      end else addr_d = addr_q + 1'b1;
      READ: if (at_hi) begin
        state_d = DRAIN;
        drain_d = 3'(RD_LAT - 1);
      end else addr_d = addr_q + 1'b1;
      DRAIN: begin
        state_d = (drain_q == '0) ? DONE : DRAIN;
        drain_d = (drain_q == '0) ? drain_q : drain_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      mode_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      key_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      cks_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      if (state_q == IDLE && start) begin
        mode_q  <= mode;
        lo_q    <= addr_lo;
        hi_q    <= addr_hi;
        key_q   <= key;
        err_q   <= '0;
        first_q <= '0;
        cks_q   <= '0;
        pass_q  <= addr_lo > addr_hi;
      end else begin
        err_q   <= err_d;
        first_q <= first_d;
        cks_q   <= cks_d;
        if (state_d == DONE && state_q != DONE) pass_q <= err_d == '0;
      end
    end
  end

  // Reads in flight: an entry leaving the last stage lines up with its douta.
  always_ff @(posedge clka) begin
    vld_q[0] <= !rsta && ena && !wea;
    pa_q[0]  <= addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_q[i] <= !rsta && vld_q[i-1];
      pa_q[i]  <= pa_q[i-1];
    end
  end
endmodule

// File: tb/tb_mem_sweep_bist.sv
// tb_mem_sweep_bist: randomized scoreboard bench for mem_sweep_bist with a memory model
module tb_mem_sweep_bist;
  localparam int AW = 16, DW = 8, RL = 2, EW = 4;
  logic clka = 0, rsta = 1, start = 0;
  logic [1:0] mode = 0;
  logic [AW-1:0] addr_lo = 0, addr_hi = 0, addra, first_err_addr;
  logic [DW-1:0] key = 0, douta, dina, checksum;
  logic ena, wea, busy, done, pass;
  logic [EW-1:0] err_count;

  mem_sweep_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .ERR_W(EW)) dut (
    .clka(clka), .rsta(rsta), .start(start), .mode(mode), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .key(key), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr), .checksum(checksum)
  );

  always #5 clka = ~clka;

  logic [DW-1:0] mem [0:65535];
  bit corrupt [0:65535];
  logic [DW-1:0] rdp [RL];
  assign douta = rdp[RL-1];

  always @(posedge clka) begin
    rdp[0] <= mem[addra] ^ {7'b0, corrupt[addra]};
    for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
    if (ena && wea) mem[addra] = dina;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  function automatic void chk(string n, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  typedef struct {int due; int len; bit pass; int err; int first; int cks;} res_t;
  typedef struct {bit we; int addr; int data;} acc_t;
  res_t exp_res[$];
  acc_t exp_acc[$];
  res_t m_r;
  acc_t m_a;
  int busy_n = 0;

  always @(negedge clka) begin
    busy_n = busy ? busy_n + 1 : 0;
    if (ena) begin
      if (exp_acc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_access: got we=%0b addr=%0h expected no access", wea, addra);
      end else begin
        m_a = exp_acc.pop_front();
        chk("access", {wea, addra, (wea ? dina : 8'h00)}, {m_a.we, m_a.addr[15:0], m_a.data[7:0]});
      end
    end
    if (done) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_done: got done=1 expected no sweep pending");
      end else begin
        m_r = exp_res.pop_front();
        chk("done_cycle", cyc, m_r.due);
        chk("busy_cycles", busy_n, m_r.len);
        chk("pass", pass, m_r.pass);
        chk("err_count", err_count, m_r.err);
        chk("first_err_addr", first_err_addr, m_r.first);
        chk("checksum", checksum, m_r.cks);
      end
    end
  end

  task automatic issue(input logic [1:0] m, input int lo, input int hi, input logic [7:0] k,
                       output int due, output bit p);
    res_t r;
    int n, errs;
    logic [7:0] v;
    n = lo > hi ? 0 : hi - lo + 1;
    errs = 0;
    r.first = 0;
    r.cks = 0;
    if (m == 2'd1 || m == 2'd2)
      for (int a = lo; a <= hi; a++) exp_acc.push_back('{1'b1, a, (a & 255) ^ k});
    if (m != 2'd1)
      for (int a = lo; a <= hi; a++) begin
        exp_acc.push_back('{1'b0, a, 0});
        v = (m == 2'd2) ? 8'(a) ^ k : mem[a];
        if (corrupt[a]) v ^= 8'h01;
        if (m == 2'd2) begin
          if (v != (8'(a) ^ k)) begin
            if (errs == 0) r.first = a;
            errs++;
          end
        end else r.cks ^= int'(v);
      end
    r.err = errs > 2**EW - 1 ? 2**EW - 1 : errs;
    r.pass = errs == 0;
    r.len = n == 0 ? 1 : m == 2'd1 ? n + 1 : m == 2'd2 ? 2 * n + RL + 1 : n + RL + 1;
    r.due = cyc + r.len;
    exp_res.push_back(r);
    due = r.due;
    p = r.pass;
    mode = m;
    addr_lo = AW'(lo);
    addr_hi = AW'(hi);
    key = k;
    start = 1;
    @(posedge clka); #1;
    start = 0;
    mode = 2'($urandom);
    addr_lo = AW'($urandom);
    addr_hi = AW'($urandom);
    key = DW'($urandom);
  endtask

  task automatic run(input logic [1:0] m, input int lo, input int hi, input logic [7:0] k);
    int due;
    bit p;
    issue(m, lo, hi, k, due, p);
    if (due - cyc >= 3) begin
      @(posedge clka); #1;
      start = 1;
      addr_lo = 0;
      addr_hi = 3;
      @(posedge clka); #1;
      start = 0;
    end
    while (cyc < due) begin
      @(posedge clka); #1;
    end
    start = 1;
    mode = 2'd2;
    addr_lo = 0;
    addr_hi = 3;
    @(posedge clka); #1;
    start = 0;
    @(posedge clka); #1;
    chk("pending_results", exp_res.size(), 0);
    chk("leftover_accesses", exp_acc.size(), 0);
    chk("idle_after_done", busy, 0);
    chk("pass_held", pass, p);
    exp_res.delete();
    exp_acc.delete();
  endtask

  task automatic reset_check(input string n);
    chk({n, "_strobes"}, {ena, wea, busy, done, pass}, 0);
    chk({n, "_addr_data"}, {addra, dina}, 0);
    chk({n, "_status"}, {err_count, first_err_addr, checksum}, 0);
  endtask

  int cl[$];
  int lo, hi, n, due;
  bit p, found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = DW'($urandom);
    repeat (3) @(posedge clka);
    #1;
    reset_check("reset");
    rsta = 0;
    @(posedge clka); #1;
    run(2'd2, 0, 255, 8'hA5);
    corrupt[16'h10] = 1;
    corrupt[16'h20] = 1;
    run(2'd2, 0, 255, 8'hA5);
    corrupt[16'h10] = 0;
    corrupt[16'h20] = 0;
    mem[16'hFFFF] = 8'h3C;
    run(2'd0, 16'hFFFF, 16'hFFFF, DW'($urandom));
    run(2'd1, 5, 3, DW'($urandom));
    issue(2'd2, 0, 255, 8'h5A, due, p);
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(posedge clka); #1;
      found = ena && !wea && addra == 16'h40;
    end
    chk("reach_read_40", found, 1);
    rsta = 1;
    #1;
    chk("no_access_in_reset", ena, 0);
    exp_res.delete();
    exp_acc.delete();
    @(posedge clka); #1;
    reset_check("mid_reset");
    rsta = 0;
    run(2'd2, 0, 31, DW'($urandom));
    for (int a = 16'h100; a <= 16'h11F; a++) corrupt[a] = 1;
    run(2'd2, 16'h100, 16'h11F, DW'($urandom));
    for (int a = 16'h100; a <= 16'h11F; a++) corrupt[a] = 0;
    run(2'd3, 16'h200, 16'h20F, DW'($urandom));
    for (int t = 0; t < 30; t++) begin
      lo = ($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 20) : $urandom_range(0, 65535);
      hi = lo + $urandom_range(0, 40);
      if (hi > 65535) hi = 65535;
      if ($urandom_range(0, 7) == 0 && lo > 0) hi = lo - $urandom_range(1, lo > 5 ? 5 : lo);
      n = lo > hi ? 0 : hi - lo + 1;
      if (n > 0)
        repeat ($urandom_range(0, 2)) begin
          cl.push_back(lo + $urandom_range(0, n - 1));
          corrupt[cl[$]] = 1;
        end
      run(2'($urandom_range(0, 3)), lo, hi, DW'($urandom));
      foreach (cl[i]) corrupt[cl[i]] = 0;
      cl.delete();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
